// File: rtl/adder_pkg.sv
// Shared types for the pipelined add/subtract unit.
package adder_pkg;

    typedef enum logic {
        ADD_OP = 1'b0,
        SUB_OP = 1'b1
    } add_op_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, the building block of each ripple-carry slice.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca_slice.sv
// CHUNK-bit combinational ripple-carry slice; also exposes the carry into its MSB
// so the top slice can derive signed overflow.
module rca_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (c[i]),
            .sum (sum[i]),
            .cout(c[i+1])
        );
    end

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined two's-complement add/subtract, one ripple slice per stage, valid/ready on both sides.
// Optional signed saturation of the result when PIPELINED_ADDER_SAT_EN is defined.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             overflow_o
);

    localparam int CHUNK = WIDTH / STAGES;

    typedef struct packed {
        logic             valid;
        add_op_e          op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic             c_msb;
`ifdef PIPELINED_ADDER_SAT_EN
        logic             a_sign;
`endif
    } stage_t;

`ifdef PIPELINED_ADDER_SAT_EN
    function automatic logic [WIDTH-1:0] sat_sum(input logic [WIDTH-1:0] s,
                                                 input logic             ovf,
                                                 input logic             a_sign);
        if (!ovf)
            return s;
        return a_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction
`endif

    stage_t           st  [STAGES];
    stage_t           nxt [STAGES];
    logic             advance;
    logic [WIDTH-1:0] b_eff;

    // The whole pipe moves as one; bubbles travel like data.
    assign advance    = !st[STAGES-1].valid || out_ready_i;
    assign in_ready_o = advance && !rst_i;
    assign b_eff      = (op_i == SUB_OP) ? ~b_i : b_i;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t           prev;
        stage_t           cur;
        logic [CHUNK-1:0] sl_sum;
        logic             sl_cout;
        logic             sl_cmsb;

        if (k == 0) begin : g_first
            // Stage 0 boundary: operands enter with SUB already folded into ~b and carry-in 1.
            always_comb begin
                prev       = '0;
                prev.valid = in_valid_i && in_ready_o;
                prev.op    = add_op_e'(op_i);
                prev.a     = a_i;
                prev.b     = b_eff;
                prev.carry = op_i;
`ifdef PIPELINED_ADDER_SAT_EN
                prev.a_sign = a_i[WIDTH-1];
`endif
            end
        end else begin : g_rest
            // Stage k boundary: fed from the previous stage's registers.
            assign prev = st[k-1];
        end

        rca_slice #(.CHUNK(CHUNK)) u_slice (
            .a    (prev.a[k*CHUNK +: CHUNK]),
            .b    (prev.b[k*CHUNK +: CHUNK]),
            .cin  (prev.carry),
            .sum  (sl_sum),
            .cout (sl_cout),
            .c_msb(sl_cmsb)
        );

        always_comb begin
            cur                        = prev;
            cur.sum[k*CHUNK +: CHUNK]  = sl_sum;
            cur.carry                  = sl_cout;
            cur.c_msb                  = sl_cmsb;
`ifdef PIPELINED_ADDER_SAT_EN
            if (k == STAGES-1)
                cur.sum = sat_sum(cur.sum, sl_cmsb ^ sl_cout, prev.a_sign);
`endif
        end

        assign nxt[k] = cur;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < STAGES; k++)
                st[k] <= '0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++)
                st[k] <= nxt[k];
        end
    end

    // Output boundary: driven straight from the last stage.
    assign out_valid_o = st[STAGES-1].valid;
    assign sum_o       = st[STAGES-1].sum;
    assign cout_o      = st[STAGES-1].carry;
    assign overflow_o  = st[STAGES-1].c_msb ^ st[STAGES-1].carry;

    logic unused_tail;
`ifdef PIPELINED_ADDER_SAT_EN
    assign unused_tail = ^{1'(st[STAGES-1].op), st[STAGES-1].a, st[STAGES-1].b,
                           st[STAGES-1].a_sign};
`else
    assign unused_tail = ^{1'(st[STAGES-1].op), st[STAGES-1].a, st[STAGES-1].b};
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=8, STAGES=4); honours PIPELINED_ADDER_SAT_EN.
module tb_pipelined_adder;

    localparam int W = 8;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .op_i       (op),
        .a_i        (a),
        .b_i        (b),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .sum_o      (sum),
        .cout_o     (cout),
        .overflow_o (ovf)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   n_acc  = 0;
    int   n_out  = 0;

    logic         stall_prev = 1'b0;
    logic [W-1:0] hold_sum;
    logic         hold_cout;
    logic         hold_ovf;

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int   sx, sy, ux, uy, sr;
        sx = $signed(x);
        sy = $signed(y);
        ux = {24'b0, x};
        uy = {24'b0, y};
        sr = o ? (sx - sy) : (sx + sy);
        e.ovf  = (sr > 127) || (sr < -128);
        e.sum  = sr[W-1:0];
        e.cout = o ? (ux >= uy) : ((ux + uy) > 255);
`ifdef PIPELINED_ADDER_SAT_EN
        if (e.ovf)
            e.sum = (sr > 0) ? 8'h7F : 8'h80;
`endif
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: sampled on the falling edge, describing the handshakes of the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_sum", sum, hold_sum);
                check("hold_cout", cout, hold_cout);
                check("hold_ovf", ovf, hold_ovf);
            end
            if (out_valid && !out_ready)
                check("stall_in_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got sum=%0h expected no result", sum);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_sum", sum, e.sum);
                    check("sb_cout", cout, e.cout);
                    check("sb_ovf", ovf, e.ovf);
                    n_out++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(op, a, b));
                n_acc++;
            end
            stall_prev = out_valid && !out_ready;
            hold_sum   = sum;
            hold_cout  = cout;
            hold_ovf   = ovf;
        end
    end

    task automatic directed(input string name, input logic o, input logic [W-1:0] x,
                            input logic [W-1:0] y, input logic [W-1:0] esum,
                            input logic ec, input logic eo);
        @(posedge clk); #1;
        in_valid = 1'b1; op = o; a = x; b = y; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({name, "_lat0"}, out_valid, 0);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            check({name, "_lat"}, out_valid, (i == 3) ? 1 : 0);
        end
        check({name, "_sum"}, sum, esum);
        check({name, "_cout"}, cout, ec);
        check({name, "_ovf"}, ovf, eo);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, out_base, cyc, stall;
        logic seen;

        rst = 1'b1; in_valid = 1'b0; op = 1'b0; a = '0; b = '0; out_ready = 1'b1;
        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

`ifdef PIPELINED_ADDER_SAT_EN
        directed("add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h7F, 1'b0, 1'b1);
`else
        directed("add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
`endif
        directed("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        directed("sub_00_01", 1'b1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0);
`ifdef PIPELINED_ADDER_SAT_EN
        directed("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h80, 1'b1, 1'b1);
`else
        directed("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
`endif

        // Backpressure: six back-to-back ops, three-cycle stall once results start.
        base = n_acc; out_base = n_out; cyc = 0; stall = 0; seen = 1'b0;
        while ((n_acc < base + 6 || exp_q.size() > 0) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            in_valid = (n_acc < base + 6);
            op = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
            if (out_valid && !seen) begin
                seen  = 1'b1;
                stall = 3;
            end
            if (stall > 0) begin
                out_ready = 1'b0;
                stall--;
                #1 check("bp_in_ready", in_ready, 0);
            end else begin
                out_ready = 1'b1;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp_timeout", (cyc < 200) ? 1 : 0, 1);
        check("bp_count", n_out - out_base, 6);

        // Reset in flight.
        repeat (3) begin
            @(posedge clk); #1;
            in_valid = 1'b1; op = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("rmf_pre_valid", out_valid, 1);
        #1 rst = 1'b1;
        #1;
        check("rmf_out_valid", out_valid, 0);
        check("rmf_in_ready", in_ready, 0);
        check("rmf_sum", sum, 0);
        @(negedge clk); #1;
        check("rmf_in_ready_hold", in_ready, 0);
        #2 rst = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            check("rmf_no_result", out_valid, 0);
        end

        // Random traffic with bubbles on both sides.
        base = n_acc; out_base = n_out; cyc = 0;
        while (cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
            if (n_acc >= base + 1000) break;
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 8);
            op = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("rnd_accepted", n_acc - base, 1000);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 100) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        check("rnd_drain", exp_q.size(), 0);
        check("rnd_delivered", n_out - out_base, n_acc - base);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
